// File: rtl/mux8way_arbiter.sv
// mux8way_arbiter: merges eight valid/ready producer channels onto one
// registered output, tagging each word with its 3-bit source index.
// Optional feature macro: MUX8WAY_ARB_RR_EN
//   defined   -> round-robin search starting at a registered pointer
//   undefined -> fixed priority, channel 0 highest, no pointer register
module mux8way_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_valid,
  input  logic [8*WIDTH-1:0]   in_data,
  output logic [7:0]           in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [2:0]           out_sel,
  input  logic                 out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        ld;
  logic        grant;
  logic        grant_found;
  logic [2:0]  grant_idx;
  logic [2:0]  scan_idx;
  logic [2:0]  start;

`ifdef MUX8WAY_ARB_RR_EN
  logic [2:0]  ptr;

  // Round-robin pointer: one past the last granted channel, wrapping 7 -> 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 3'd0;
    end else if (grant) begin
      ptr <= grant_idx + 3'd1;
    end else begin
      ptr <= ptr;
    end
  end

  assign start = ptr;
`else
  // Fixed priority: the search always begins at channel 0.
  assign start = 3'd0;
`endif

  // The output slot can take a new word when empty or draining this cycle.
  assign ld = !out_valid || out_ready;

  // Scan the requesters from the start index, first valid channel wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    scan_idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      scan_idx = start + 3'(i);
      if (!grant_found && in_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end else begin
        grant_found = grant_found;
      end
    end
  end

  // Grant qualification and one-hot ready back to the selected producer.
  always_comb begin
    grant    = 1'b0;
    in_ready = 8'd0;
    if (!reset && ld && grant_found) begin
      grant    = 1'b1;
      in_ready = 8'd1 << grant_idx;
    end else begin
      grant    = 1'b0;
      in_ready = 8'd0;
    end
  end

  // Next-state logic for the single-entry output slot.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (grant) begin
          state_next = FULL;
        end else begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (grant) begin
          state_next = FULL;
        end else if (out_ready) begin
          state_next = EMPTY;
        end else begin
          state_next = FULL;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // Slot state register; reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Output data and source tag load on a grant and otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= {WIDTH{1'b0}};
      out_sel  <= 3'd0;
    end else if (grant) begin
      out_data <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_sel  <= grant_idx;
    end else begin
      out_data <= out_data;
      out_sel  <= out_sel;
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: doc/mux8way_arbiter.md
# mux8way_arbiter

Sequential 8-to-1 funnel: collects 16-bit words from eight valid/ready producer channels and delivers them one at a time on a single registered output, tagged with a 3-bit source index `out_sel`. It is the return path to the 8-way demultiplexer. The demultiplexer fans one word out by `sel`; this block merges eight channels back onto one, carrying `sel` alongside the data. It sits between the eight per-channel sources and any single consumer, such as a memory write port or a serial link.

## Interface
Parameters:
- `WIDTH`, 16, data word width (Hack word)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  8  bit k: channel k offers a word
- `in_data`  in  8*WIDTH  channel k word at bits [k*WIDTH +: WIDTH]
- `in_ready`  out  8  one-hot or zero; bit k: channel k word accepted this cycle
- `out_valid`  out  1  output register holds a word
- `out_data`  out  WIDTH  held word
- `out_sel`  out  3  source channel index of held word
- `out_ready`  in  1  consumer accepts held word this cycle

## Operation
- Two states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- Load enable `ld` = `!out_valid || out_ready`.
  - `ld`=1 allows a word to enter in the same cycle the held word drains.
- Grant: when `ld`=1 and any `in_valid` bit is set, exactly one channel g is granted.
  - `in_ready[g]`=1; all other `in_ready` bits are 0.
  - `in_ready` is combinational from `in_valid`, `ptr`, `out_valid`, `out_ready`. It never depends on `in_data`.
- Round-robin search: g is the first k with `in_valid[k]`=1, scanning from `ptr`, `ptr+1`, … modulo 8.
  - `ptr` is a 3-bit register, reset to 0.
- On a grant edge:
  - `out_data` ← channel g word.
  - `out_sel` ← g.
  - `out_valid` ← 1.
  - `ptr` ← g+1 mod 8. g=7 wraps to 0.
- On `out_valid && out_ready` with no grant: `out_valid` ← 0. `out_data` and `out_sel` hold their last values.
- Drain and grant in the same cycle: the new word replaces the old with no bubble, and `out_valid` stays 1.
- FULL with `out_ready`=0:
  - all `in_ready` bits are 0;
  - `out_data`, `out_sel` and `ptr` are frozen.
- Fairness: a channel holding `in_valid` high is granted within 8 grants.
- Producers hold `in_data`/`in_valid` stable until `in_ready[k]`. Behaviour for a producer that drops `in_valid` early is undefined but must not corrupt other channels.

## Timing
- Reset (`reset`=1 at an edge):
  - `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0.
  - `in_ready`=0 while `reset` is high.
- Reset mid-operation discards any held word. No partial output is delivered.
- Latency: a word granted at edge N is visible on `out_*` after edge N, one cycle.
- Throughput: one word per cycle while `out_ready`=1 and at least one `in_valid` is set.
- Single requester: a channel alone on the bus is granted every cycle regardless of `ptr`.
- All eight valid: grants cycle 0,1,…,7,0,… starting from the reset `ptr`.
- `out_ready` asserted while EMPTY has no effect.

## Configuration
- `MUX8WAY_ARB_RR_EN`:
  - Defined: round-robin search as described; `ptr` is updated on each grant.
  - Undefined: fixed priority, lowest index wins (channel 0 highest). `ptr` is not implemented; the search always starts at 0. The fairness guarantee does not apply; all other behaviour is identical.

## Test plan
- Reset: drive `reset`=1 for 2 cycles with all `in_valid`=1.
  - Required: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_sel`=0.
  - After release, the first grant is to channel 0.
- Single channel: only channel 5 valid with 0x1234, `out_ready`=1.
  - Required: `in_ready`=8'b0010_0000 that cycle.
  - Next cycle: `out_valid`=1, `out_data`=0x1234, `out_sel`=5.
- Round-robin: all eight channels valid with data 0x00k0, `out_ready`=1 for 10 cycles.
  - Required: `out_sel` sequence 0,1,2,3,4,5,6,7,0,1, matching data, no bubbles.
  - With the macro undefined: the sequence is all 0.
- Backpressure: channels 2 and 6 valid, `out_ready`=0 for 3 cycles after the first load.
  - Required: `out_sel`=2 held and `in_ready`=0 throughout.
  - After `out_ready`=1: next `out_sel`=6, then 2.
- Wrap and skip: `ptr`=7 (after a channel 6 grant), only channels 1 and 7 valid.
  - Required: grant 7, then 1, then 7.
- Reset mid-stream: assert `reset` while FULL with `out_sel`=3.
  - Required: next cycle `out_valid`=0, `ptr`=0; the held word is never acknowledged.
